// File: rtl/text_pkg.sv
// Text-mode renderer shared constants and the per-pixel delay-line bundle.
// Optional blinking cursor is enabled by defining TEXT_CURSOR_EN.
package text_pkg;

    localparam int CELL_W   = 8;
    localparam int CELL_H   = 8;
    localparam int PIPE_LAT = 3;

    localparam logic [7:0] CH_BLANK = 8'h00;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef struct packed {
        logic       valid;
        logic       inrange;
        logic       cur;
        logic       hs;
        logic       vs;
        logic [2:0] row;
        logic [2:0] col;
    } tap_t;

    // Top glyph row lives in the high byte, bit 0 of a byte is leftmost.
    function automatic logic [5:0] glyph_idx(
        input logic [2:0] row,
        input logic [2:0] col
    );
        return {~row, col};
    endfunction

endpackage

// File: rtl/text_buffer.sv
// Character buffer: one-cycle synchronous read port plus independent write port.
// Read-before-write on address collision returns the old byte.
module text_buffer
    import text_pkg::*;
#(
    parameter int DEPTH = 4800,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    // Stored XOR space so the all-zero power-up image reads back as blanks.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata ^ CH_SPACE;
        end
        rdata <= mem[raddr] ^ CH_SPACE;
    end

endmodule

// File: rtl/text_renderer.sv
// Character-cell text renderer: coordinate -> buffer -> font -> pixel, 3-cycle pipe.
// Define TEXT_CURSOR_EN for the blinking underline cursor and cursor_addr port.
module text_renderer
    import text_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int AW   = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [9:0]    in_x,
    input  logic [9:0]    in_y,
    input  logic          in_hsync,
    input  logic          in_vsync,
    output logic [7:0]    font_ch,
    input  logic [63:0]   font_bitmap,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          pix_valid,
    output logic          pix_on,
    output logic          pix_hsync,
    output logic          pix_vsync
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [AW-1:0] cursor_addr
`endif
);

    localparam int NCELL = COLS * ROWS;

    logic          inrange;
    logic [AW-1:0] cell_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          wr_ok;
    logic          cur_hit;
    logic          sel_q;
    tap_t          tap;
    tap_t          dl [PIPE_LAT];

    always_comb begin
        inrange = in_valid
               && (32'(in_x) < COLS * CELL_W)
               && (32'(in_y) < ROWS * CELL_H);
        cell_addr = AW'(32'(in_y[9:3]) * 32'(COLS)
                      + 32'(in_x[9:3]));
        // Out-of-area coordinates read a harmless address.
        rd_addr = inrange ? cell_addr : '0;
        wr_ok   = wr_en && (32'(wr_addr) < NCELL);
    end

`ifdef TEXT_CURSOR_EN
    logic [5:0] frame_cnt;
    logic       vs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            vs_q      <= 1'b0;
        end else begin
            vs_q <= in_vsync;
            if (in_vsync && !vs_q) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign cur_hit = inrange
                  && (cell_addr == cursor_addr)
                  && frame_cnt[5]
                  && (in_y[2:0] == 3'd7);
`else
    assign cur_hit = 1'b0;
`endif

    always_comb begin
        tap         = '0;
        tap.valid   = in_valid;
        tap.inrange = inrange;
        tap.cur     = cur_hit;
        tap.hs      = in_hsync;
        tap.vs      = in_vsync;
        tap.row     = in_y[2:0];
        tap.col     = in_x[2:0];
    end

    text_buffer #(
        .DEPTH (NCELL),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= tap;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // Font ROM output is valid in stage 2; pick the addressed pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= font_bitmap[glyph_idx(dl[1].row, dl[1].col)];
        end
    end

    assign font_ch   = dl[0].inrange ? rd_data : CH_BLANK;
    assign pix_valid = dl[PIPE_LAT-1].valid;
    assign pix_on    = dl[PIPE_LAT-1].inrange
                    && (sel_q || dl[PIPE_LAT-1].cur);
    assign pix_hsync = dl[PIPE_LAT-1].hs;
    assign pix_vsync = dl[PIPE_LAT-1].vs;

endmodule

// File: doc/text_renderer.md
# text_renderer

Character-cell text-mode pixel generator. It sits between the video timing generator and the pixel output, directly upstream of `font_8x8`. It holds a COLS×ROWS character buffer, converts each incoming pixel coordinate into a buffer read, and drives `font_8x8` with the character code. It then picks the addressed bit out of the returned 64-bit glyph and emits a pixel stream aligned with delayed sync signals.

## Interface
- `COLS`, default 80: character columns.
- `ROWS`, default 60: character rows.
- `AW`, default 13: buffer address width; must satisfy 2^AW ≥ COLS*ROWS.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: coordinate is in the active area.
- `in_x` in 10: pixel column.
- `in_y` in 10: pixel row.
- `in_hsync` in 1: horizontal sync, passed through.
- `in_vsync` in 1: vertical sync, passed through.
- `font_ch` out 8: character code to `font_8x8.ch`.
- `font_bitmap` in 64: glyph from `font_8x8.bitmap`, registered inside the font block.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in AW: write address, computed as row*COLS + col.
- `wr_data` in 8: character code to write.
- `pix_valid` out 1: output pixel is active.
- `pix_on` out 1: foreground pixel.
- `pix_hsync` out 1: horizontal sync, delayed by 3 cycles.
- `pix_vsync` out 1: vertical sync, delayed by 3 cycles.
- `cursor_addr` in AW: present only with `TEXT_CURSOR_EN`.

## Operation
- **Stage 0 (input cycle t).**
  - Cell address = (in_y>>3)*COLS + (in_x>>3).
  - `inrange` = in_valid && in_x < COLS*8 && in_y < ROWS*8.
  - Synchronous buffer read issued at that address.
  - in_x[2:0], in_y[2:0], inrange, valid and syncs enter a 3-deep delay line.
- **Stage 1 (t+1).**
  - Buffer read data is registered.
  - `font_ch` = read data when the delayed inrange is set, else 8'h00.
  - The font ROM latches its glyph at the end of this cycle.
- **Stage 2 (t+2).**
  - `font_bitmap` is valid.
  - Select bit = bitmap[(7-row)*8 + col], where row = y[2:0] and col = x[2:0].
  - The top glyph row sits in bits 63:56; bit 0 of each byte is the leftmost pixel.
  - The result is registered.
- **Stage 3 (t+3).**
  - `pix_on` = selected bit AND delayed inrange.
  - `pix_valid` = delayed in_valid.
- **Buffer.**
  - COLS*ROWS bytes, inferred block RAM, with a separate write port.
  - Contents are not reset; initialized to 8'h20 (space) at configuration.
  - Write and read to the same address in the same cycle: the read returns the old data.
  - Writes with wr_addr ≥ COLS*ROWS are ignored.
- **Codes ≥ 8'h80.** Passed to the font unmodified; the font block blanks them.

## Timing
- Latency is exactly 3 cycles from the in_* sample to pix_*, for every signal, including syncs.
- Throughput is one pixel per cycle, with no stalls and no backpressure.
- Reset (rst low, asynchronous):
  - All pipeline and delay registers clear.
  - pix_valid, pix_on and font_ch = 0.
  - pix_hsync and pix_vsync = 0.
  - Blink counter = 0.
- On rst release the first valid output appears 3 cycles after the first sampled input.
- Reset asserted mid-frame flushes in-flight pixels; no partial output follows release.
- A write is visible to reads issued on the cycle after the wr_en edge.

## Configuration
- `TEXT_CURSOR_EN` defined: blinking underline cursor.
  - Adds the `cursor_addr` port.
  - 6-bit frame counter increments on each in_vsync rising edge, wrapping at 63.
  - Cursor phase = counter[5], so it is on for 32 frames and off for 32.
  - When the stage-0 address equals cursor_addr, the phase is on and row == 7, stage 3 forces pix_on=1 for the in-range pixel.
  - The cursor address compare is pipelined alongside the other delay bits.
- `TEXT_CURSOR_EN` undefined:
  - No port, counter or compare logic.
  - pix_on comes purely from the glyph.

## Structure
- `text_pkg` holds:
  - CELL_W=8 and CELL_H=8.
  - PIPE_LAT=3.
  - The blank code 8'h00 and the space code 8'h20.
- Sub-module `text_buffer` holds the dual-port RAM: a one-cycle synchronous read port and a write port.
- `font_8x8` is instantiated by the parent, not inside this block.

## Test plan
- Write 8'h41 ('A') at address 0, then scan x=0..7, y=0:
  - Row-0 byte 8'h0C gives pix_on = 0,0,1,1,0,0,0,0 at t+3.
- Drive x=COLS*8, y=0 with in_valid=1: pix_valid=1, pix_on=0, and font_ch=0 at t+1.
- Pulse in_hsync for 1 cycle at t: pix_hsync is high at exactly t+3 and never at t+2 or t+4.
- Same-cycle write of 8'h21 and read of the same address, which held 8'h20: font_ch=8'h20 at t+1; the next read returns 8'h21.
- Assert rst mid-scan for 1 cycle: all outputs are 0 immediately (asynchronously) and stay 0 for 3 cycles after release.
- With `TEXT_CURSOR_EN`, cursor_addr=5, after 32 vsync edges: x=40..47, y=7 gives pix_on=1 on all eight pixels; after 64 edges only the glyph bits appear.
